// File: rtl/mod_cu.sv
// mod_cu: control unit for the repeated-subtraction modulo datapath.
// Drives operand select and temp write enable, and counts subtractions as the quotient.
module mod_cu #(
    parameter int            QW       = 32,
    parameter logic [QW-1:0] MAX_ITER = {QW{1'b1}}
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          start,
    input  logic          x,
    output logic          s,
    output logic          we,
    output logic          busy,
    output logic          done,
    output logic          a_lt_b,
    output logic          err,
    output logic [QW-1:0] quot
);
    typedef enum logic [1:0] {IDLE, SUB0, LOOP, DONE} state_t;
    state_t r_state;
    logic   r_err;
    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            r_state <= IDLE;
            quot    <= '0;
            a_lt_b  <= 1'b0;
            r_err   <= 1'b0;
        end else
            case (r_state)
                IDLE: if (start) begin
                    r_state <= SUB0;
                    quot    <= '0;
                    a_lt_b  <= 1'b0;
                    r_err   <= 1'b0;
                end
                SUB0: if (x) begin
                    r_state <= DONE;
                    a_lt_b  <= 1'b1;
                end else begin
                    r_state <= LOOP;
                    quot    <= QW'(1);
                end
                // the limit check precedes the increment so quot never wraps
                LOOP: if (x) r_state <= DONE;
                      else if (quot == MAX_ITER) begin
                          r_state <= DONE;
                          r_err   <= 1'b1;
                      end else quot <= quot + QW'(1);
                DONE: r_state <= IDLE;
            endcase
    always_comb begin
        s    = (r_state == LOOP) || (r_state == DONE);
        busy = (r_state == SUB0) || (r_state == LOOP);
        we   = busy && !x;
        done = r_state == DONE;
        err  = done && r_err;
    end
endmodule

// File: tb/tb_mod_cu.sv
// tb_mod_cu: directed vectors for mod_cu driving a behavioural modulo datapath.
module tb_mod_cu;
    localparam int QW = 4;
    logic          CLK = 1'b0, RST_N = 1'b0, start = 1'b0;
    logic          x, s, we, busy, done, a_lt_b, err;
    logic [QW-1:0] quot;
    logic [7:0]    da = 8'd0, db = 8'd1, temp = 8'd0, opnd;
    logic          wp = 1'b0, rec = 1'b0;
    logic [7:0]    tq[$];
    int            n_chk = 0, n_fail = 0;

    mod_cu #(.QW(QW), .MAX_ITER(4'd8)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .x(x), .s(s), .we(we),
        .busy(busy), .done(done), .a_lt_b(a_lt_b), .err(err), .quot(quot)
    );

    always #5 CLK = ~CLK;
    assign opnd = s ? temp : da;
    assign x    = opnd < db;
    always @(posedge CLK) begin
        if (we) temp <= opnd - db;
        wp <= we;
    end
    always @(negedge CLK) if (wp && rec) tq.push_back(temp);

    typedef struct {
        logic [7:0] a, b;
        int quot, altb, err, rem, cyc, nwe;
    } vec_t;
    vec_t v[8];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic noise,
                          output int cyc, output int nwe);
        da = a; db = b; tq.delete(); rec = 1'b1; start = 1'b1; nwe = 0; cyc = 0;
        @(negedge CLK);
        start = noise;
        while (!done && cyc < 40) begin
            if (we) nwe++;
            @(negedge CLK);
            cyc++;
        end
        rec = 1'b0;
        start = noise;
    endtask

    initial begin
        int cyc, nwe;
        int exp_t[5] = '{31, 24, 17, 10, 3};
        v[0] = '{8'd38, 8'd7, 5, 0, 0, 3, 6, 5};
        v[1] = '{8'd5,  8'd9, 0, 1, 0, 5, 1, 0};
        v[2] = '{8'd14, 8'd7, 2, 0, 0, 0, 3, 2};
        v[3] = '{8'd20, 8'd0, 8, 0, 1, 0, 9, 9};
        v[4] = '{8'd7,  8'd7, 1, 0, 0, 0, 2, 1};
        v[5] = '{8'd0,  8'd5, 0, 1, 0, 0, 1, 0};
        v[6] = '{8'd8,  8'd1, 8, 0, 0, 0, 9, 8};
        v[7] = '{8'd9,  8'd1, 8, 0, 1, 0, 9, 9};

        repeat (2) @(negedge CLK);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_quot", int'(quot), 0);
        chk("rst_we", int'(we), 0);
        RST_N = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 8; i++) begin
            run_op(v[i].a, v[i].b, 1'b0, cyc, nwe);
            chk($sformatf("v%0d_cyc", i), cyc, v[i].cyc);
            chk($sformatf("v%0d_quot", i), int'(quot), v[i].quot);
            chk($sformatf("v%0d_altb", i), int'(a_lt_b), v[i].altb);
            chk($sformatf("v%0d_err", i), int'(err), v[i].err);
            chk($sformatf("v%0d_we", i), nwe, v[i].nwe);
            if (v[i].err == 0)
                chk($sformatf("v%0d_rem", i), a_lt_b ? int'(da) : int'(temp), v[i].rem);
            if (i == 0) begin
                chk("v0_tlen", tq.size(), 5);
                for (int j = 0; j < 5 && j < tq.size(); j++)
                    chk($sformatf("v0_temp%0d", j), int'(tq[j]), exp_t[j]);
            end
            @(negedge CLK);
            chk($sformatf("v%0d_donepulse", i), int'(done), 0);
            chk($sformatf("v%0d_errpulse", i), int'(err), 0);
            chk($sformatf("v%0d_idle", i), int'(busy), 0);
            chk($sformatf("v%0d_hold", i), int'(quot), v[i].quot);
        end

        // start held while busy and during DONE must be ignored
        run_op(8'd38, 8'd7, 1'b1, cyc, nwe);
        chk("hs_cyc", cyc, 6);
        chk("hs_quot", int'(quot), 5);
        @(negedge CLK);
        start = 1'b0;
        chk("hs_done_ignored", int'(busy), 0);
        // back-to-back start in the first IDLE cycle after DONE
        run_op(8'd14, 8'd7, 1'b0, cyc, nwe);
        chk("b2b_cyc", cyc, 3);
        chk("b2b_quot", int'(quot), 2);
        @(negedge CLK);

        // asynchronous reset in the middle of LOOP
        da = 8'd20; db = 8'd0; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (3) @(negedge CLK);
        chk("mid_busy", int'(busy), 1);
        #2 RST_N = 1'b0;
        #1;
        chk("ar_s", int'(s), 0);
        chk("ar_we", int'(we), 0);
        chk("ar_busy", int'(busy), 0);
        chk("ar_quot", int'(quot), 0);
        chk("ar_err", int'(err), 0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_s", int'(s), 0);
        run_op(8'd38, 8'd7, 1'b0, cyc, nwe);
        chk("post_rst_cyc", cyc, 6);
        chk("post_rst_quot", int'(quot), 5);
        chk("post_rst_rem", int'(temp), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
